// File: rtl/hist_collector_if.sv
// Signal bundle between the histogram collector, the pixel source, the
// rebuilder handshake and port A of the raw histogram RAM.
interface hist_collector_if #(
    parameter int BIN_W     = 14,
    parameter int CNT_W     = 18,
    parameter int PIX_CNT_W = 20
);
    // pix_valid qualifies pix_data/sof/eof with no backpressure; raw_hist_rdy
    // is a level meaning "RAM frozen", and raw_hist_upd is level-sampled only
    // while raw_hist_rdy is high.
    logic [BIN_W-1:0]     pix_data;
    logic                 pix_valid;
    logic                 pix_sof;
    logic                 pix_eof;
    logic                 raw_hist_upd;
    logic                 raw_hist_rdy;
    logic                 hist_ram_we;
    logic [BIN_W-1:0]     hist_ram_addr;
    logic [CNT_W-1:0]     hist_ram_din;
    logic [CNT_W-1:0]     hist_ram_dout;
    logic [PIX_CNT_W-1:0] frame_pix_cnt;
    logic                 pix_overrun;

    modport master (
        input  pix_data, pix_valid, pix_sof, pix_eof, raw_hist_upd, hist_ram_dout,
        output raw_hist_rdy, hist_ram_we, hist_ram_addr, hist_ram_din,
               frame_pix_cnt, pix_overrun
    );

    modport slave (
        output pix_data, pix_valid, pix_sof, pix_eof, raw_hist_upd, hist_ram_dout,
        input  raw_hist_rdy, hist_ram_we, hist_ram_addr, hist_ram_din,
               frame_pix_cnt, pix_overrun
    );
endinterface

// File: rtl/hist_collector.sv
// Clears the raw histogram RAM, accumulates one frame through port A with a
// 4-cycle read-modify-write per pixel, then freezes the RAM and raises ready.
module hist_collector #(
    parameter int BIN_W     = 14,
    parameter int CNT_W     = 18,
    parameter int PIX_CNT_W = 20
) (
    input  logic                  clk,
    input  logic                  srst,
    hist_collector_if.master      bus,
    output logic [1:0]            dbg_state
);
    typedef enum logic [1:0] {
        ST_CLEAR    = 2'd0,
        ST_WAIT_SOF = 2'd1,
        ST_ACCUM    = 2'd2,
        ST_IDLE     = 2'd3
    } state_t;

    localparam logic [BIN_W-1:0]     ADDR_LAST = '1;
    localparam logic [CNT_W-1:0]     CNT_MAX   = '1;
    localparam logic [PIX_CNT_W-1:0] PIX_MAX   = '1;

    state_t               state_q, state_d;
    logic [1:0]           phase_q, phase_d;
    logic                 eof_pend_q, eof_pend_d;
    logic                 rdy_q, rdy_d;
    logic                 we_q, we_d;
    logic [BIN_W-1:0]     addr_q, addr_d;
    logic [CNT_W-1:0]     din_q, din_d;
    logic [PIX_CNT_W-1:0] pix_cnt_q, pix_cnt_d;
    logic [PIX_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic                 ovr_q, ovr_d;
    logic                 accept;

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        eof_pend_d  = eof_pend_q;
        rdy_d       = rdy_q;
        we_d        = we_q;
        addr_d      = addr_q;
        din_d       = din_q;
        pix_cnt_d   = pix_cnt_q;
        frame_cnt_d = frame_cnt_q;
        ovr_d       = ovr_q;
        accept      = 1'b0;

        case (state_q)
            ST_CLEAR: begin
                din_d = '0;
                if (!we_q) begin
                    we_d   = 1'b1;
                    addr_d = '0;
                end else if (addr_q == ADDR_LAST) begin
                    we_d    = 1'b0;
                    addr_d  = '0;
                    state_d = ST_WAIT_SOF;
                end else begin
                    addr_d = addr_q + BIN_W'(1);
                end
            end

            ST_WAIT_SOF: begin
                if (bus.pix_valid && bus.pix_sof) begin
                    accept    = 1'b1;
                    pix_cnt_d = PIX_CNT_W'(1);
                    state_d   = ST_ACCUM;
                end
            end

            ST_ACCUM: begin
                if (phase_q == 2'd0) begin
                    if (bus.pix_valid) begin
                        accept    = 1'b1;
                        pix_cnt_d = (pix_cnt_q == PIX_MAX) ? pix_cnt_q
                                                           : pix_cnt_q + PIX_CNT_W'(1);
                    end
                end else if (bus.pix_valid) begin
                    // Pixel arrived while a read-modify-write is in flight.
                    ovr_d = 1'b1;
                    if (bus.pix_eof) eof_pend_d = 1'b1;
                end

                case (phase_q)
                    2'd1: phase_d = 2'd2;
                    2'd2: begin
                        din_d   = (bus.hist_ram_dout == CNT_MAX) ? CNT_MAX
                                                                 : bus.hist_ram_dout + CNT_W'(1);
                        we_d    = 1'b1;
                        phase_d = 2'd3;
                    end
                    2'd3: begin
                        we_d    = 1'b0;
                        phase_d = 2'd0;
                        if (eof_pend_q || (bus.pix_valid && bus.pix_eof)) begin
                            eof_pend_d  = 1'b0;
                            frame_cnt_d = pix_cnt_q;
                            rdy_d       = 1'b1;
                            state_d     = ST_IDLE;
                        end
                    end
                    default: ;
                endcase
            end

            ST_IDLE: begin
                if (bus.raw_hist_upd) begin
                    rdy_d   = 1'b0;
                    state_d = ST_CLEAR;
                end
            end

            default: state_d = ST_CLEAR;
        endcase

        if (accept) begin
            addr_d     = bus.pix_data;
            we_d       = 1'b0;
            phase_d    = 2'd1;
            eof_pend_d = bus.pix_eof;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state_q     <= ST_CLEAR;
            phase_q     <= 2'd0;
            eof_pend_q  <= 1'b0;
            rdy_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            din_q       <= '0;
            pix_cnt_q   <= '0;
            frame_cnt_q <= '0;
            ovr_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            eof_pend_q  <= eof_pend_d;
            rdy_q       <= rdy_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            din_q       <= din_d;
            pix_cnt_q   <= pix_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            ovr_q       <= ovr_d;
        end
    end

    assign bus.raw_hist_rdy  = rdy_q;
    assign bus.hist_ram_we   = we_q;
    assign bus.hist_ram_addr = addr_q;
    assign bus.hist_ram_din  = din_q;
    assign bus.frame_pix_cnt = frame_cnt_q;
    assign bus.pix_overrun   = ovr_q;
    assign dbg_state         = state_q;
endmodule

// File: tb/tb_hist_collector.sv
// Bench for hist_collector at reduced widths (256 bins, 6-bit counts, 7-bit
// pixel counter) so clears and saturation fit in a short run.
module tb_hist_collector;
    localparam int BIN_W     = 8;
    localparam int CNT_W     = 6;
    localparam int PIX_CNT_W = 7;
    localparam int NBINS     = 1 << BIN_W;
    localparam int CNT_MAX   = (1 << CNT_W) - 1;
    localparam int PIX_MAX   = (1 << PIX_CNT_W) - 1;

    logic       clk  = 1'b0;
    logic       srst = 1'b1;
    logic [1:0] dbg_state;

    hist_collector_if #(.BIN_W(BIN_W), .CNT_W(CNT_W), .PIX_CNT_W(PIX_CNT_W)) bus ();

    hist_collector #(.BIN_W(BIN_W), .CNT_W(CNT_W), .PIX_CNT_W(PIX_CNT_W)) dut (
        .clk       (clk),
        .srst      (srst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- port A RAM model (1-cycle read latency) ----------------
    logic [CNT_W-1:0] mem [NBINS];
    bit seeded = 0;
    always @(posedge clk) begin
        if (!seeded) begin
            for (int i = 0; i < NBINS; i++) mem[i] <= CNT_W'($urandom_range(1, CNT_MAX));
            seeded <= 1'b1;
        end else if (bus.hist_ram_we) begin
            mem[bus.hist_ram_addr] <= bus.hist_ram_din;
        end
        bus.hist_ram_dout <= mem[bus.hist_ram_addr];
    end

    // ---------------- scoreboard queues ----------------
    typedef struct { int cnt; int ovr; int lat; int nb; } frame_exp_t;
    typedef struct { int bin; int val; } bin_exp_t;

    frame_exp_t       frame_q[$];
    bin_exp_t         bin_q[$];
    logic [BIN_W:0]   exp_clear_q[$];
    longint           eof_cyc = 0;

    task automatic exp_frame(input int cnt, input int ovr, input int lat, input int nb);
        frame_exp_t f;
        f.cnt = cnt; f.ovr = ovr; f.lat = lat; f.nb = nb;
        frame_q.push_back(f);
    endtask

    task automatic exp_bin(input int bin, input int val);
        bin_exp_t b;
        b.bin = bin; b.val = val;
        bin_q.push_back(b);
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    // One pixel, then idle so the next call lands gap cycles later (gap >= 2).
    task automatic pix(input logic [BIN_W-1:0] d, input bit s, input bit e, input int gap);
        @(posedge clk); #1;
        bus.pix_data  = d;
        bus.pix_valid = 1'b1;
        bus.pix_sof   = s;
        bus.pix_eof   = e;
        if (e) eof_cyc = cyc;
        @(posedge clk); #1;
        bus.pix_valid = 1'b0;
        bus.pix_sof   = 1'b0;
        bus.pix_eof   = 1'b0;
        repeat (gap - 2) @(posedge clk);
    endtask

    task automatic do_upd();
        @(posedge clk); #1;
        check("rdy_before_upd", bus.raw_hist_rdy, 1);
        bus.raw_hist_upd = 1'b1;
        exp_clear_q.push_back((BIN_W+1)'(NBINS));
        @(posedge clk); #1;
        bus.raw_hist_upd = 1'b0;
        check("rdy_drop_after_upd", bus.raw_hist_rdy, 0);
    endtask

    task automatic wait_rdy(input string name);
        int n = 0;
        while (!bus.raw_hist_rdy && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check(name, bus.raw_hist_rdy, 1);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_rdy"},     bus.raw_hist_rdy, 0);
        check({tag, "_we"},      bus.hist_ram_we, 0);
        check({tag, "_addr"},    bus.hist_ram_addr, 0);
        check({tag, "_din"},     bus.hist_ram_din, 0);
        check({tag, "_pix_cnt"}, bus.frame_pix_cnt, 0);
        check({tag, "_overrun"}, bus.pix_overrun, 0);
    endtask

    // ---------------- monitor ----------------
    int         run = 0;
    int         order_bad = 0;
    int         idle_bad = 0;
    int         others;
    bit         prev_rdy = 0;
    bit         listed [NBINS];
    frame_exp_t fe;
    bin_exp_t   be;

    always @(negedge clk) begin
        if (bus.hist_ram_we && bus.hist_ram_din == '0) begin
            if (bus.hist_ram_addr != BIN_W'(run)) order_bad++;
            run++;
        end else if (run > 0) begin
            if (exp_clear_q.size() == 0) check("unexpected_clear", run, 0);
            else check("clear_len", run, exp_clear_q.pop_front());
            check("clear_order", order_bad, 0);
            run = 0;
            order_bad = 0;
        end

        if (bus.raw_hist_rdy && !prev_rdy) begin
            if (frame_q.size() == 0) begin
                check("unexpected_rdy", 1, 0);
            end else begin
                fe = frame_q.pop_front();
                check("frame_pix_cnt", bus.frame_pix_cnt, fe.cnt);
                check("pix_overrun", bus.pix_overrun, fe.ovr);
                check("rdy_latency", cyc - eof_cyc, fe.lat);
                for (int i = 0; i < NBINS; i++) listed[i] = 1'b0;
                for (int k = 0; k < fe.nb; k++) begin
                    be = bin_q.pop_front();
                    listed[be.bin] = 1'b1;
                    check($sformatf("bin_%0d", be.bin), mem[be.bin], be.val);
                end
                others = 0;
                for (int i = 0; i < NBINS; i++)
                    if (!listed[i] && mem[i] != '0) others++;
                check("other_bins_zero", others, 0);
            end
        end

        if (bus.raw_hist_rdy && bus.hist_ram_we) idle_bad++;
        prev_rdy = bus.raw_hist_rdy;
    end

    // ---------------- stimulus ----------------
    initial begin
        bus.pix_data     = '0;
        bus.pix_valid    = 1'b0;
        bus.pix_sof      = 1'b0;
        bus.pix_eof      = 1'b0;
        bus.raw_hist_upd = 1'b0;

        // Reset and first frame {5,5,9,255}
        exp_clear_q.push_back((BIN_W+1)'(NBINS));
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("reset");
        srst = 1'b0;
        exp_frame(4, 0, 4, 3);
        exp_bin(5, 2); exp_bin(9, 1); exp_bin(NBINS - 1, 1);
        idle(NBINS + 10);
        pix(8'd5, 1, 0, 4);
        pix(8'd5, 0, 0, 4);
        pix(8'd9, 0, 0, 4);
        pix(8'd255, 0, 1, 4);
        wait_rdy("t1_rdy");

        // Update request, single-pixel frame {7}
        do_upd();
        exp_frame(1, 0, 4, 2);
        exp_bin(7, 1); exp_bin(5, 0);
        idle(NBINS + 10);
        pix(8'd7, 1, 1, 4);
        wait_rdy("t2_rdy");

        // Pixels 2 cycles apart; the eof pixel is dropped but ends the frame
        do_upd();
        exp_frame(1, 1, 2, 2);
        exp_bin(3, 1); exp_bin(4, 0);
        idle(NBINS + 10);
        pix(8'd3, 1, 0, 2);
        pix(8'd4, 0, 1, 4);
        wait_rdy("t3_rdy");

        // Long frame: bin and pixel counter both saturate
        do_upd();
        exp_frame(PIX_MAX, 1, 4, 1);
        exp_bin(100, CNT_MAX);
        idle(NBINS + 10);
        for (int i = 0; i < PIX_MAX + 3; i++) pix(8'd100, i == 0, i == PIX_MAX + 2, 4);
        wait_rdy("t4_rdy");

        // Frame sent during clear is ignored; non-sof pixel ignored; next sof counts
        do_upd();
        exp_frame(2, 1, 4, 6);
        exp_bin(11, 0); exp_bin(12, 0); exp_bin(13, 0); exp_bin(30, 0);
        exp_bin(20, 1); exp_bin(21, 1);
        pix(8'd11, 1, 0, 4);
        pix(8'd12, 0, 0, 4);
        pix(8'd13, 0, 1, 4);
        idle(NBINS + 10);
        pix(8'd30, 0, 0, 4);
        pix(8'd20, 1, 0, 4);
        pix(8'd21, 0, 1, 4);
        wait_rdy("t5_rdy");

        // srst during accumulation with a read-modify-write in flight
        do_upd();
        idle(NBINS + 10);
        pix(8'd40, 1, 0, 4);
        pix(8'd41, 0, 0, 2);
        @(posedge clk); #1;
        srst = 1'b1;
        exp_clear_q.push_back((BIN_W+1)'(NBINS));
        @(posedge clk); #1;
        check_reset_vals("midrst");
        srst = 1'b0;
        idle(100);
        check("rdy_low_in_clear", bus.raw_hist_rdy, 0);
        exp_frame(1, 0, 4, 3);
        exp_bin(50, 1); exp_bin(40, 0); exp_bin(41, 0);
        idle(NBINS + 10);
        check("rdy_low_before_frame", bus.raw_hist_rdy, 0);
        pix(8'd50, 1, 1, 4);
        wait_rdy("t6_rdy");

        idle(5);
        check("clear_q_empty", exp_clear_q.size(), 0);
        check("frame_q_empty", frame_q.size(), 0);
        check("idle_port_a", idle_bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
